uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Parametrised UART receiver: configurable data width, parity mode and stop
//   bits, with oversampled majority-vote bit sampling.
//   Received words carry per-word error flags and pass through a small FIFO
//   with a valid/ready output handshake.
//   Sits between the board RX pin and the SoC-side consumer. Driven by one
//   shared baud-tick generator pulsing OVERSAMPLE times per bit.
// PARAMETERS
//   DATA_BITS   8   data bits per frame, 5..9, sent LSB first
//   OVERSAMPLE  16  baud_tick pulses per bit period, even, >= 8
//   FIFO_DEPTH  4   output FIFO entries, power of 2, >= 2
// PORTS
//   clk           in   1            single clock; all logic on posedge
//   rst           in   1            synchronous, active-high reset
//   baud_tick     in   1            1-clk pulse, OVERSAMPLE per bit time
//   uart_rx       in   1            async serial line, idle high
//   parity_mode   in   2            00 none, 01 even, 10 odd, 11 none
//   two_stop      in   1            1 = two stop bits checked
//   m_data        out  DATA_BITS    head-of-FIFO data word
//   m_parity_err  out  1            head word had a parity mismatch
//   m_frame_err   out  1            head word had a low stop bit
//   m_valid       out  1            FIFO not empty
//   m_ready       in   1            consumer accepts head word
//   overrun       out  1            1-clk pulse: completed word dropped, FIFO full
//   fifo_count    out  $clog2(FIFO_DEPTH)+1  occupied entries
// BEHAVIOUR
// - Reset: state IDLE, tick/bit counters 0, synchroniser = 1, FIFO empty.
//   m_valid=0, m_data=0, m_*_err=0, overrun=0, fifo_count=0.
// - uart_rx passes a 2-flop synchroniser (reset value 1). All decisions use the synchronised value.
// - Counters advance only on baud_tick. tick_cnt wraps at OVERSAMPLE-1.
// - Bit value is the 2-of-3 majority of samples at ticks H-1, H, H+1 of the bit period, where H = OVERSAMPLE/2.
// - FSM states:
//   IDLE: armed only after the line has been seen high at least once since the last frame or reset.
//     Falling level on a tick -> START, tick_cnt=0. parity_mode and two_stop are latched here.
//   START: at tick H+1, a majority 1 is a false start -> IDLE with no word and no flags.
//     Otherwise, at the end of the bit period -> DATA.
//   DATA: DATA_BITS bits shifted in LSB first. -> PARITY if the latched mode is 01/10, else -> STOP.
//   PARITY: even mode requires XOR(data, p) = 0; odd mode requires it to be 1. A mismatch sets parity_err.
//   STOP: a 0 stop sample sets frame_err. With two_stop, both stop bits are sampled.
//     The word is pushed at tick H+1 of the last stop bit, then -> IDLE.
// - Break (stop bit 0): the frame is pushed with frame_err=1. IDLE stays disarmed until the line returns high,
//   so a held-low line yields exactly one word.
// - FIFO: push in the cycle the last stop bit is decided. m_valid rises the following cycle (1-clk latency).
//   Pop on m_valid & m_ready. m_data and flags reflect the new head the next cycle.
// - Push while full with no pop in the same cycle: word dropped, overrun pulses one cycle, contents unchanged.
// - Push while full with a simultaneous pop: both happen, no overrun, count unchanged.
// - Push and pop while empty: m_valid rises next cycle as normal, with no bypass.
// - Pointers wrap modulo FIFO_DEPTH. fifo_count spans 0..FIFO_DEPTH.
// - rst mid-frame aborts the frame with no push and returns all state to reset values within one cycle.
// TESTING
//   (clk 20 ns, baud_tick every 4 clk, OVERSAMPLE=16, DATA_BITS=8, FIFO_DEPTH=4 unless noted)
// 1. 8N1 frame 0x41, m_ready=1 -> one word: m_data=0x41, both err=0, m_valid high for exactly 1 clk.
// 2. 8E1 frame 0xA5 with parity bit 1 -> m_data=0xA5, m_parity_err=1. The same frame in odd mode -> err=0.
// 3. 8N1 0x00 with stop=0, line held low 20 bit times -> exactly one word 0x00 with m_frame_err=1.
//    Next frame 0x55 after the line goes high is received clean.
// 4. Line low for 3 ticks, then high -> no word, overrun=0.
//    A 1-tick low glitch at mid-bit of data bit 3 of 0xFF -> still 0xFF (majority vote).
// 5. m_ready=0, frames 0x01..0x05 -> overrun pulses once, on the 5th. fifo_count=4.
//    Raising m_ready drains 0x01,0x02,0x03,0x04 in order.
// 6. rst pulsed 1 clk during data bit 4 of 0x3C -> m_valid=0, fifo_count=0.
//    The next 0x3C frame is received correctly. Repeat with DATA_BITS=9, two_stop=1, value 0x1A3.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with 2-of-3 majority bit sampling,
// optional parity and one/two stop bits. Each received word carries parity
// and framing flags and is queued in a small FIFO drained via valid/ready.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        baud_tick,
    input  logic                        uart_rx,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    output logic [DATA_BITS-1:0]        m_data,
    output logic                        m_parity_err,
    output logic                        m_frame_err,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int H  = OVERSAMPLE / 2;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = DATA_BITS + 2;

    localparam logic [TW-1:0] T_S0   = TW'(H - 1);
    localparam logic [TW-1:0] T_S1   = TW'(H);
    localparam logic [TW-1:0] T_MID  = TW'(H + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Receiver state
    // ------------------------------------------------------------------
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx;
    state_t               r_state;
    state_t               w_next;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_s0;
    logic                 r_s1;
    logic                 r_armed;
    logic                 r_par_on;
    logic                 r_par_odd;
    logic                 r_two_stop;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frame_err;

    logic                 w_tick_s0;
    logic                 w_tick_s1;
    logic                 w_mid;
    logic                 w_end;
    logic                 w_maj;
    logic                 w_last_data;
    logic                 w_last_stop;

    // Control strobes from the output decoder
    logic                 w_start_det;
    logic                 w_shift_en;
    logic                 w_par_chk;
    logic                 w_stop_chk;
    logic                 w_push;
    logic [WW-1:0]        w_push_word;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [WW-1:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_overrun;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr_en;

    assign w_rx      = r_sync2;
    assign w_tick_s0 = baud_tick && (r_tick_cnt == T_S0);
    assign w_tick_s1 = baud_tick && (r_tick_cnt == T_S1);
    assign w_mid     = baud_tick && (r_tick_cnt == T_MID);
    assign w_end     = baud_tick && (r_tick_cnt == T_LAST);

    // The third vote is the live sample taken on the decision tick itself.
    assign w_maj = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

    assign w_last_data = (r_bit_cnt == B_LAST);
    assign w_last_stop = (r_bit_cnt == {{(BW-1){1'b0}}, r_two_stop});

    // Two-flop synchroniser for the asynchronous serial line, idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_det) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_mid && w_maj) begin
                    w_next = S_IDLE;
                end else if (w_end) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_end && w_last_data) begin
                    w_next = r_par_on ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_end) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_mid && w_last_stop) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM output decode: per-state sampling strobes and the FIFO push
    always_comb begin
        w_start_det = 1'b0;
        w_shift_en  = 1'b0;
        w_par_chk   = 1'b0;
        w_stop_chk  = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE:   w_start_det = baud_tick && r_armed && !w_rx;
            S_DATA:   w_shift_en  = w_mid;
            S_PARITY: w_par_chk   = w_mid;
            S_STOP: begin
                w_stop_chk = w_mid;
                w_push     = w_mid && w_last_stop;
            end
            default: ;
        endcase
    end

    // The last stop sample is folded in combinationally so the word can be
    // pushed on the same tick that decides it.
    assign w_push_word = {r_frame_err | ~w_maj, r_par_err, r_shift};

    // Bit timing, sampling, shift register and per-frame error accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_armed     <= 1'b0;
            r_par_on    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_two_stop  <= 1'b0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            if (w_start_det) begin
                // Disarm until the line is seen high again: a held-low
                // break therefore yields exactly one word.
                r_armed     <= 1'b0;
                r_par_on    <= parity_mode[0] ^ parity_mode[1];
                r_par_odd   <= parity_mode[1] & ~parity_mode[0];
                r_two_stop  <= two_stop;
                r_shift     <= '0;
                r_par_err   <= 1'b0;
                r_frame_err <= 1'b0;
            end else if (w_rx) begin
                r_armed <= 1'b1;
            end
        end else if (baud_tick) begin
            r_tick_cnt <= w_end ? '0 : r_tick_cnt + TW'(1);
            if (w_next != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_end) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
            if (w_tick_s0) begin
                r_s0 <= w_rx;
            end
            if (w_tick_s1) begin
                r_s1 <= w_rx;
            end
            if (w_shift_en) begin
                r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            end
            if (w_par_chk) begin
                r_par_err <= (^r_shift) ^ w_maj ^ r_par_odd;
            end
            if (w_stop_chk && !w_maj) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = (r_count != '0) && m_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    // Output FIFO: pointers wrap modulo depth, drop-and-flag when full
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_push_word;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign {m_frame_err, m_parity_err, m_data} = r_mem[r_rd_ptr];
    assign m_valid    = (r_count != '0);
    assign overrun    = r_overrun;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: frame-level reference model (expected word and
// flags computed from data, parity mode and stop bits) plus a queue model of
// the FIFO for overrun. Two instances: 8-bit and 9-bit data.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int unsigned BIT = 64; // 16 ticks x 4 clk

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx8 = 1'b1;
    logic       rx9 = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       two_stop = 1'b0;
    logic       ready8 = 1'b1;
    logic       ready9 = 1'b1;

    logic [7:0] m_data8;
    logic       m_parity_err8, m_frame_err8, m_valid8, overrun8;
    logic [2:0] fifo_count8;
    logic [8:0] m_data9;
    logic       m_parity_err9, m_frame_err9, m_valid9, overrun9;
    logic [2:0] fifo_count9;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Monitor state (written only by the monitor process)
    logic [10:0] rxq8[$];
    logic [10:0] rxq9[$];
    int unsigned ovr8 = 0, ovr9 = 0, vcyc8 = 0;

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .uart_rx(rx8),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .m_data(m_data8), .m_parity_err(m_parity_err8), .m_frame_err(m_frame_err8),
        .m_valid(m_valid8), .m_ready(ready8), .overrun(overrun8), .fifo_count(fifo_count8)
    );

    uart_rx_fifo #(.DATA_BITS(9), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut9 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .uart_rx(rx9),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .m_data(m_data9), .m_parity_err(m_parity_err9), .m_frame_err(m_frame_err9),
        .m_valid(m_valid9), .m_ready(ready9), .overrun(overrun9), .fifo_count(fifo_count9)
    );

    always #10 clk = ~clk;

    // One baud tick every fourth clock
    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    // Record accepted words and overrun pulses away from the active edge
    always @(negedge clk) begin
        if (m_valid8 && ready8) rxq8.push_back({m_frame_err8, m_parity_err8, 1'b0, m_data8});
        if (m_valid9 && ready9) rxq9.push_back({m_frame_err9, m_parity_err9, m_data9});
        if (overrun8) ovr8++;
        if (overrun9) ovr9++;
        if (m_valid8) vcyc8++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: expected {frame_err, parity_err, data} of one frame
    function automatic logic [10:0] model_word(input logic [8:0] data, input int unsigned nbits,
                                               input logic [1:0] pmode, input logic pbit,
                                               input logic [1:0] stops, input logic two);
        int unsigned ones;
        logic [8:0]  d;
        logic        perr, ferr;
        ones = (pbit) ? 1 : 0;
        d    = '0;
        for (int i = 0; i < int'(nbits); i++) begin
            d[i] = data[i];
            if (data[i]) ones++;
        end
        perr = 1'b0;
        if (pmode == 2'b01) perr = (ones % 2) != 0;
        if (pmode == 2'b10) perr = (ones % 2) == 0;
        ferr = !stops[0] || (two && !stops[1]);
        return {ferr, perr, d};
    endfunction

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int unsigned which, input logic v);
        if (which == 9) rx9 = v;
        else rx8 = v;
    endtask

    task automatic set_ready(input int unsigned which, input logic v);
        if (which == 9) ready9 = v;
        else ready8 = v;
    endtask

    task automatic send_frame(input int unsigned which, input logic [8:0] data, input int unsigned nbits,
                              input logic [1:0] pmode, input logic pbit, input logic [1:0] stops,
                              input logic two, input int glitch_bit);
        parity_mode = pmode;
        two_stop    = two;
        set_line(which, 1'b0);
        wait_clk(BIT);
        for (int i = 0; i < int'(nbits); i++) begin
            set_line(which, data[i]);
            if (i == glitch_bit) begin
                wait_clk(30);
                set_line(which, 1'b0);
                wait_clk(4);
                set_line(which, data[i]);
                wait_clk(30);
            end else begin
                wait_clk(BIT);
            end
        end
        if (pmode == 2'b01 || pmode == 2'b10) begin
            set_line(which, pbit);
            wait_clk(BIT);
        end
        set_line(which, stops[0]);
        wait_clk(BIT);
        if (two) begin
            set_line(which, stops[1]);
            wait_clk(BIT);
        end
        set_line(which, 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        if (m_valid8 !== 1'b0) begin $display("FAIL reset_valid8: got %b want 0", m_valid8); n_err++; end
        n_vec++;
        if (m_data8 !== 8'h00) begin $display("FAIL reset_data8: got %h want 00", m_data8); n_err++; end
        n_vec++;
        if ({m_parity_err8, m_frame_err8} !== 2'b00) begin
            $display("FAIL reset_err8: got %b%b want 00", m_parity_err8, m_frame_err8); n_err++;
        end
        n_vec++;
        if (overrun8 !== 1'b0) begin $display("FAIL reset_overrun8: got %b want 0", overrun8); n_err++; end
        n_vec++;
        if (fifo_count8 !== 3'd0) begin $display("FAIL reset_count8: got %0d want 0", fifo_count8); n_err++; end
        n_vec++;
        if (m_valid9 !== 1'b0 || m_data9 !== 9'h000 || fifo_count9 !== 3'd0) begin
            $display("FAIL reset_dut9: got valid=%b data=%h count=%0d want 0/000/0", m_valid9, m_data9, fifo_count9);
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_basic;
        int unsigned base, vbase, obase;
        logic [10:0] exp;
        base  = rxq8.size();
        vbase = vcyc8;
        obase = ovr8;
        ready8 = 1'b1;
        send_frame(8, 9'h041, 8, 2'b00, 1'b0, 2'b11, 1'b0, -1);
        wait_clk(16);
        exp = model_word(9'h041, 8, 2'b00, 1'b0, 2'b11, 1'b0);
        if (rxq8.size() !== base + 1) begin
            $display("FAIL basic_count: got %0d words want 1", rxq8.size() - base); n_err++;
        end else if (rxq8[base] !== exp) begin
            $display("FAIL basic_word: got %h want %h", rxq8[base], exp); n_err++;
        end
        n_vec++;
        if (vcyc8 - vbase !== 1) begin
            $display("FAIL basic_valid_width: got %0d cycles want 1", vcyc8 - vbase); n_err++;
        end
        n_vec++;
        if (ovr8 !== obase) begin $display("FAIL basic_overrun: got %0d pulses want 0", ovr8 - obase); n_err++; end
        n_vec++;
    endtask

    task automatic test_parity;
        int unsigned base;
        logic [10:0] exp [2];
        base   = rxq8.size();
        exp[0] = model_word(9'h0A5, 8, 2'b01, 1'b1, 2'b11, 1'b0);
        exp[1] = model_word(9'h0A5, 8, 2'b10, 1'b1, 2'b11, 1'b0);
        send_frame(8, 9'h0A5, 8, 2'b01, 1'b1, 2'b11, 1'b0, -1);
        wait_clk(BIT);
        send_frame(8, 9'h0A5, 8, 2'b10, 1'b1, 2'b11, 1'b0, -1);
        wait_clk(16);
        for (int k = 0; k < 2; k++) begin
            if (rxq8.size() <= base + k) begin
                $display("FAIL parity_word%0d: got none want %h", k, exp[k]); n_err++;
            end else if (rxq8[base+k] !== exp[k]) begin
                $display("FAIL parity_word%0d: got %h want %h", k, rxq8[base+k], exp[k]); n_err++;
            end
            n_vec++;
        end
    endtask

    task automatic test_break;
        int unsigned base;
        logic [10:0] exp0, exp1;
        base = rxq8.size();
        exp0 = model_word(9'h000, 8, 2'b00, 1'b0, 2'b00, 1'b0);
        exp1 = model_word(9'h055, 8, 2'b00, 1'b0, 2'b11, 1'b0);
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        set_line(8, 1'b0);
        wait_clk(20 * BIT);
        if (rxq8.size() !== base + 1) begin
            $display("FAIL break_count: got %0d words want 1", rxq8.size() - base); n_err++;
        end else if (rxq8[base] !== exp0) begin
            $display("FAIL break_word: got %h want %h", rxq8[base], exp0); n_err++;
        end
        n_vec++;
        set_line(8, 1'b1);
        wait_clk(2 * BIT);
        send_frame(8, 9'h055, 8, 2'b00, 1'b0, 2'b11, 1'b0, -1);
        wait_clk(16);
        if (rxq8.size() !== base + 2) begin
            $display("FAIL after_break_count: got %0d words want 2", rxq8.size() - base); n_err++;
        end else if (rxq8[base+1] !== exp1) begin
            $display("FAIL after_break_word: got %h want %h", rxq8[base+1], exp1); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_glitch;
        int unsigned base, obase;
        logic [10:0] exp;
        base  = rxq8.size();
        obase = ovr8;
        set_line(8, 1'b0);
        wait_clk(12);
        set_line(8, 1'b1);
        wait_clk(2 * BIT);
        if (rxq8.size() !== base || m_valid8 !== 1'b0 || ovr8 !== obase) begin
            $display("FAIL false_start: got %0d words valid=%b overruns=%0d want 0/0/0",
                     rxq8.size() - base, m_valid8, ovr8 - obase);
            n_err++;
        end
        n_vec++;
        exp = model_word(9'h0FF, 8, 2'b00, 1'b0, 2'b11, 1'b0);
        send_frame(8, 9'h0FF, 8, 2'b00, 1'b0, 2'b11, 1'b0, 3);
        wait_clk(16);
        if (rxq8.size() !== base + 1) begin
            $display("FAIL glitch_count: got %0d words want 1", rxq8.size() - base); n_err++;
        end else if (rxq8[base] !== exp) begin
            $display("FAIL glitch_word: got %h want %h", rxq8[base], exp); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_overrun;
        int unsigned base, obase, exp_ovr;
        logic [10:0] mq[$];
        logic [10:0] w;
        base    = rxq8.size();
        obase   = ovr8;
        exp_ovr = 0;
        ready8  = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            send_frame(8, 9'(v), 8, 2'b00, 1'b0, 2'b11, 1'b0, -1);
            wait_clk(8);
            w = model_word(9'(v), 8, 2'b00, 1'b0, 2'b11, 1'b0);
            if (mq.size() < 4) mq.push_back(w);
            else exp_ovr++;
            if (v >= 4) begin
                if (ovr8 - obase !== exp_ovr) begin
                    $display("FAIL overrun_after_%0d: got %0d pulses want %0d", v, ovr8 - obase, exp_ovr); n_err++;
                end
                n_vec++;
                if (fifo_count8 !== 3'(mq.size())) begin
                    $display("FAIL count_after_%0d: got %0d want %0d", v, fifo_count8, mq.size()); n_err++;
                end
                n_vec++;
            end
        end
        ready8 = 1'b1;
        wait_clk(10);
        for (int k = 0; k < mq.size(); k++) begin
            if (rxq8.size() <= base + k) begin
                $display("FAIL drain_word%0d: got none want %h", k, mq[k]); n_err++;
            end else if (rxq8[base+k] !== mq[k]) begin
                $display("FAIL drain_word%0d: got %h want %h", k, rxq8[base+k], mq[k]); n_err++;
            end
            n_vec++;
        end
        if (fifo_count8 !== 3'd0 || rxq8.size() !== base + mq.size()) begin
            $display("FAIL drain_end: got count=%0d words=%0d want 0/%0d", fifo_count8, rxq8.size() - base, mq.size());
            n_err++;
        end
        n_vec++;
    endtask

    task automatic test_reset_midframe(input int unsigned which, input logic [8:0] value);
        int unsigned nb, base;
        logic        two;
        logic [2:0]  fc;
        logic        vld;
        logic [10:0] exp, got;
        nb  = which;
        two = (which == 9);
        set_ready(which, 1'b0);
        send_frame(which, 9'h077, nb, 2'b00, 1'b0, 2'b11, two, -1);
        wait_clk(16);
        fc = (which == 9) ? fifo_count9 : fifo_count8;
        if (fc !== 3'd1) begin $display("FAIL preload_%0d: got count %0d want 1", which, fc); n_err++; end
        n_vec++;
        parity_mode = 2'b00;
        two_stop    = two;
        set_line(which, 1'b0);
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            set_line(which, value[i]);
            wait_clk(BIT);
        end
        set_line(which, value[4]);
        wait_clk(32);
        rst = 1'b1;
        set_line(which, 1'b1);
        wait_clk(1);
        rst = 1'b0;
        wait_clk(3);
        fc  = (which == 9) ? fifo_count9 : fifo_count8;
        vld = (which == 9) ? m_valid9 : m_valid8;
        if (vld !== 1'b0 || fc !== 3'd0) begin
            $display("FAIL midreset_%0d: got valid=%b count=%0d want 0/0", which, vld, fc); n_err++;
        end
        n_vec++;
        set_ready(which, 1'b1);
        wait_clk(2 * BIT);
        base = (which == 9) ? rxq9.size() : rxq8.size();
        exp  = model_word(value, nb, 2'b00, 1'b0, 2'b11, two);
        send_frame(which, value, nb, 2'b00, 1'b0, 2'b11, two, -1);
        wait_clk(16);
        if (((which == 9) ? rxq9.size() : rxq8.size()) !== base + 1) begin
            $display("FAIL recover_%0d_count: got %0d words want 1", which,
                     ((which == 9) ? rxq9.size() : rxq8.size()) - base);
            n_err++;
        end else begin
            got = (which == 9) ? rxq9[base] : rxq8[base];
            if (got !== exp) begin
                $display("FAIL recover_%0d_word: got %h want %h", which, got, exp); n_err++;
            end
        end
        n_vec++;
    endtask

    task automatic test_random;
        int unsigned which, base;
        logic [8:0]  d;
        logic [1:0]  pm, st;
        logic        pb, two;
        logic [10:0] exp, got;
        for (int k = 0; k < 10; k++) begin
            which = ($urandom_range(0, 2) == 0) ? 9 : 8;
            d     = 9'($urandom);
            pm    = 2'($urandom_range(0, 3));
            pb    = 1'($urandom_range(0, 1));
            st[0] = ($urandom_range(0, 3) != 0);
            st[1] = ($urandom_range(0, 3) != 0);
            two   = 1'($urandom_range(0, 1));
            base  = (which == 9) ? rxq9.size() : rxq8.size();
            exp   = model_word(d, which, pm, pb, st, two);
            send_frame(which, d, which, pm, pb, st, two, -1);
            wait_clk(BIT);
            if (((which == 9) ? rxq9.size() : rxq8.size()) !== base + 1) begin
                $display("FAIL random%0d_count: dut%0d got %0d words want 1", k, which,
                         ((which == 9) ? rxq9.size() : rxq8.size()) - base);
                n_err++;
            end else begin
                got = (which == 9) ? rxq9[base] : rxq8[base];
                if (got !== exp) begin
                    $display("FAIL random%0d_word: dut%0d got %h want %h", k, which, got, exp); n_err++;
                end
            end
            n_vec++;
        end
    endtask

    initial begin
        wait_clk(2);
        test_reset();
        wait_clk(BIT);
        test_basic();
        test_parity();
        test_break();
        test_glitch();
        test_overrun();
        test_reset_midframe(8, 9'h03C);
        test_reset_midframe(9, 9'h1A3);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
